// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access stage: operator codes, the
// operator bus width, FSM state codes and small operator classification
// helpers used by both the stage and its lane steering logic.
package mem_access_pkg;

  localparam int MEM_OPERATOR_BUS = 4;

  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_LBU  = 4'd2;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_LH   = 4'd3;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_LHU  = 4'd4;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_LW   = 4'd5;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OPERATOR_BUS-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_BUS  = 1'b1
  } state_e;

  // Loads return data to the register file.
  function automatic logic op_is_load(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  // Stores drive the bus write data lanes.
  function automatic logic op_is_store(input logic [MEM_OPERATOR_BUS-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  // Any operator that needs the bus; undefined codes fall through as NONE.
  function automatic logic op_is_mem(input logic [MEM_OPERATOR_BUS-1:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic op_is_aligned(input logic [MEM_OPERATOR_BUS-1:0] op,
                                         input logic [1:0] address_low);
    logic aligned;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: aligned = ~address_low[0];
      MEM_OP_LW, MEM_OP_SW:             aligned = (address_low == 2'b00);
      default:                          aligned = 1'b1;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte lane steering: turns an operator and the low address
// bits into bus byte enables, replicated store data and the sign/zero
// extended load result (little-endian, lane0 = bits[7:0]).
module mem_lane_steer
  import mem_access_pkg::*;
(
  input  logic [MEM_OPERATOR_BUS-1:0] mem_operator_i,
  input  logic [1:0]                  address_low_i,
  input  logic [31:0]                 store_data_i,
  input  logic [31:0]                 read_data_i,
  output logic [3:0]                  byte_select_o,
  output logic [31:0]                 store_data_steered_o,
  output logic [31:0]                 load_data_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Byte enables and store data replication follow the access size.
  always_comb begin
    byte_select_o        = 4'b0000;
    store_data_steered_o = 32'h0000_0000;
    case (mem_operator_i)
      MEM_OP_LB, MEM_OP_LBU: byte_select_o = 4'b0001 << address_low_i;
      MEM_OP_SB: begin
        byte_select_o        = 4'b0001 << address_low_i;
        store_data_steered_o = {4{store_data_i[7:0]}};
      end
      MEM_OP_LH, MEM_OP_LHU: byte_select_o = address_low_i[1] ? 4'b1100 : 4'b0011;
      MEM_OP_SH: begin
        byte_select_o        = address_low_i[1] ? 4'b1100 : 4'b0011;
        store_data_steered_o = {2{store_data_i[15:0]}};
      end
      MEM_OP_LW: byte_select_o = 4'b1111;
      MEM_OP_SW: begin
        byte_select_o        = 4'b1111;
        store_data_steered_o = store_data_i;
      end
      default: byte_select_o = 4'b0000;
    endcase
  end

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    lane_byte = read_data_i[7:0];
    case (address_low_i)
      2'd1:    lane_byte = read_data_i[15:8];
      2'd2:    lane_byte = read_data_i[23:16];
      2'd3:    lane_byte = read_data_i[31:24];
      default: lane_byte = read_data_i[7:0];
    endcase
    lane_half = address_low_i[1] ? read_data_i[31:16] : read_data_i[15:0];
  end

  // Extend the selected lane to a full register value.
  always_comb begin
    load_data_o = read_data_i;
    case (mem_operator_i)
      MEM_OP_LB:  load_data_o = {{24{lane_byte[7]}}, lane_byte};
      MEM_OP_LBU: load_data_o = {24'h000000, lane_byte};
      MEM_OP_LH:  load_data_o = {{16{lane_half[15]}}, lane_half};
      MEM_OP_LHU: load_data_o = {16'h0000, lane_half};
      default:    load_data_o = read_data_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage. Passes non-memory results straight through with
// one cycle of latency, runs loads and stores on a request/acknowledge bus
// while stalling upstream, and reports misalignment and bus timeouts as
// single-cycle exceptions alongside output_valid.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        input_valid,
  input  logic [MEM_OPERATOR_BUS-1:0] mem_operator,
  input  logic [4:0]                  input_write_address,
  input  logic                        input_write_enable,
  input  logic [31:0]                 input_write_data,
  input  logic [31:0]                 store_data,
  output logic                        stall_request,
  output logic                        bus_request,
  output logic                        bus_write,
  output logic [31:0]                 bus_address,
  output logic [3:0]                  bus_byte_select,
  output logic [31:0]                 bus_write_data,
  input  logic [31:0]                 bus_read_data,
  input  logic                        bus_acknowledge,
  output logic [4:0]                  write_address,
  output logic                        write_enable,
  output logic [31:0]                 write_data,
  output logic                        output_valid,
  output logic                        exception_misaligned,
  output logic                        exception_bus_error
);

  localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [COUNTER_WIDTH-1:0]    counter_q, counter_d;
  logic                        bus_request_q, bus_request_d;
  logic                        bus_write_q, bus_write_d;
  logic [31:0]                 bus_address_q, bus_address_d;
  logic [3:0]                  bus_byte_select_q, bus_byte_select_d;
  logic [31:0]                 bus_write_data_q, bus_write_data_d;
  logic [4:0]                  write_address_q, write_address_d;
  logic                        write_enable_q, write_enable_d;
  logic [31:0]                 write_data_q, write_data_d;
  logic                        output_valid_q, output_valid_d;
  logic                        misaligned_q, misaligned_d;
  logic                        bus_error_q, bus_error_d;
  logic [MEM_OPERATOR_BUS-1:0] operator_q, operator_d;
  logic [1:0]                  address_low_q, address_low_d;
  logic [4:0]                  dest_address_q, dest_address_d;
  logic                        dest_enable_q, dest_enable_d;

  logic [MEM_OPERATOR_BUS-1:0] steer_operator;
  logic [1:0]                  steer_address_low;
  logic [3:0]                  steer_byte_select;
  logic [31:0]                 steer_store_data;
  logic [31:0]                 steer_load_data;
  logic                        timeout;

  // While a transaction is outstanding the steering works from the latched
  // operator and address so the load extension matches the request.
  always_comb begin
    steer_operator    = mem_operator;
    steer_address_low = input_write_data[1:0];
    if (state_q == STATE_BUS) begin
      steer_operator    = operator_q;
      steer_address_low = address_low_q;
    end
  end

  mem_lane_steer u_lane_steer (
    .mem_operator_i       (steer_operator),
    .address_low_i        (steer_address_low),
    .store_data_i         (store_data),
    .read_data_i          (bus_read_data),
    .byte_select_o        (steer_byte_select),
    .store_data_steered_o (steer_store_data),
    .load_data_o          (steer_load_data)
  );

  assign timeout = TIMEOUT_ENABLED && (counter_q == TIMEOUT_LAST);

  // Next-state and output decisions; pulses and write_enable default low.
  always_comb begin
    state_d           = state_q;
    counter_d         = counter_q;
    bus_request_d     = bus_request_q;
    bus_write_d       = bus_write_q;
    bus_address_d     = bus_address_q;
    bus_byte_select_d = bus_byte_select_q;
    bus_write_data_d  = bus_write_data_q;
    write_address_d   = write_address_q;
    write_enable_d    = 1'b0;
    write_data_d      = write_data_q;
    output_valid_d    = 1'b0;
    misaligned_d      = 1'b0;
    bus_error_d       = 1'b0;
    operator_d        = operator_q;
    address_low_d     = address_low_q;
    dest_address_d    = dest_address_q;
    dest_enable_d     = dest_enable_q;
    stall_request     = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        if (input_valid) begin
          if (!op_is_mem(mem_operator)) begin
            write_address_d = input_write_address;
            write_enable_d  = input_write_enable;
            write_data_d    = input_write_data;
            output_valid_d  = 1'b1;
          end else if (!op_is_aligned(mem_operator, input_write_data[1:0])) begin
            write_address_d = input_write_address;
            output_valid_d  = 1'b1;
            misaligned_d    = 1'b1;
          end else begin
            stall_request     = 1'b1;
            state_d           = STATE_BUS;
            counter_d         = '0;
            bus_request_d     = 1'b1;
            bus_write_d       = op_is_store(mem_operator);
            bus_address_d     = {input_write_data[31:2], 2'b00};
            bus_byte_select_d = steer_byte_select;
            bus_write_data_d  = steer_store_data;
            operator_d        = mem_operator;
            address_low_d     = input_write_data[1:0];
            dest_address_d    = input_write_address;
            dest_enable_d     = input_write_enable;
          end
        end
      end

      STATE_BUS: begin
        stall_request = !bus_acknowledge && !timeout;
        if (bus_acknowledge) begin
          state_d         = STATE_IDLE;
          bus_request_d   = 1'b0;
          output_valid_d  = 1'b1;
          write_address_d = dest_address_q;
          if (op_is_load(operator_q)) begin
            write_enable_d = dest_enable_q;
            write_data_d   = steer_load_data;
          end
        end else if (timeout) begin
          state_d         = STATE_IDLE;
          bus_request_d   = 1'b0;
          output_valid_d  = 1'b1;
          write_address_d = dest_address_q;
          bus_error_d     = 1'b1;
        end else begin
          counter_d = counter_q + COUNTER_WIDTH'(1);
        end
      end

      default: state_d = STATE_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= STATE_IDLE;
      counter_q         <= '0;
      bus_request_q     <= 1'b0;
      bus_write_q       <= 1'b0;
      bus_address_q     <= 32'h0000_0000;
      bus_byte_select_q <= 4'b0000;
      bus_write_data_q  <= 32'h0000_0000;
      write_address_q   <= 5'd0;
      write_enable_q    <= 1'b0;
      write_data_q      <= 32'h0000_0000;
      output_valid_q    <= 1'b0;
      misaligned_q      <= 1'b0;
      bus_error_q       <= 1'b0;
      operator_q        <= MEM_OP_NONE;
      address_low_q     <= 2'b00;
      dest_address_q    <= 5'd0;
      dest_enable_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      counter_q         <= counter_d;
      bus_request_q     <= bus_request_d;
      bus_write_q       <= bus_write_d;
      bus_address_q     <= bus_address_d;
      bus_byte_select_q <= bus_byte_select_d;
      bus_write_data_q  <= bus_write_data_d;
      write_address_q   <= write_address_d;
      write_enable_q    <= write_enable_d;
      write_data_q      <= write_data_d;
      output_valid_q    <= output_valid_d;
      misaligned_q      <= misaligned_d;
      bus_error_q       <= bus_error_d;
      operator_q        <= operator_d;
      address_low_q     <= address_low_d;
      dest_address_q    <= dest_address_d;
      dest_enable_q     <= dest_enable_d;
    end
  end

  assign bus_request          = bus_request_q;
  assign bus_write            = bus_write_q;
  assign bus_address          = bus_address_q;
  assign bus_byte_select      = bus_byte_select_q;
  assign bus_write_data       = bus_write_data_q;
  assign write_address        = write_address_q;
  assign write_enable         = write_enable_q;
  assign write_data           = write_data_q;
  assign output_valid         = output_valid_q;
  assign exception_misaligned = misaligned_q;
  assign exception_bus_error  = bus_error_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for the memory access stage: directed scenarios followed by random
// operations, each checked against a reference model built from the access
// size, alignment and acknowledge timing rules.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        input_valid;
  logic [3:0]  mem_operator;
  logic [4:0]  input_write_address;
  logic        input_write_enable;
  logic [31:0] input_write_data;
  logic [31:0] store_data;
  logic        stall_request;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_acknowledge;
  logic [4:0]  write_address;
  logic        write_enable;
  logic [31:0] write_data;
  logic        output_valid;
  logic        exception_misaligned;
  logic        exception_bus_error;

  int checks   = 0;
  int failures = 0;

  mem_access #(.TIMEOUT_CYCLES(TO), .COUNTER_WIDTH(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .input_valid          (input_valid),
    .mem_operator         (mem_operator),
    .input_write_address  (input_write_address),
    .input_write_enable   (input_write_enable),
    .input_write_data     (input_write_data),
    .store_data           (store_data),
    .stall_request        (stall_request),
    .bus_request          (bus_request),
    .bus_write            (bus_write),
    .bus_address          (bus_address),
    .bus_byte_select      (bus_byte_select),
    .bus_write_data       (bus_write_data),
    .bus_read_data        (bus_read_data),
    .bus_acknowledge      (bus_acknowledge),
    .write_address        (write_address),
    .write_enable         (write_enable),
    .write_data           (write_data),
    .output_valid         (output_valid),
    .exception_misaligned (exception_misaligned),
    .exception_bus_error  (exception_bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("[TB] check %s failed", tag);
    end
  endtask

  task automatic checkOutput1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("[TB] check %s failed", tag);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [31:0] data,
                               input logic [4:0] dest, input logic wen, input logic [31:0] sdata);
    input_valid         = valid;
    mem_operator        = op;
    input_write_data    = data;
    input_write_address = dest;
    input_write_enable  = wen;
    store_data          = sdata;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      MEM_OP_LW, MEM_OP_SW:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_loads(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 32'd4);
    case (op_size(op))
      1:       return 4'(1 << lane);
      2:       return 4'(3 << lane);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_store(input logic [3:0] op, input logic [31:0] sd);
    case (op_size(op))
      1:       return (sd & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] v, b, h;
    v = rd >> (32'd8 * (addr % 32'd4));
    b = v & 32'h0000_00FF;
    h = v & 32'h0000_FFFF;
    case (op)
      MEM_OP_LB:  return (b >= 32'd128) ? b - 32'd256 : b;
      MEM_OP_LBU: return b;
      MEM_OP_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      MEM_OP_LHU: return h;
      default:    return rd;
    endcase
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput1({tag, "_req"}, bus_request, 1'b0);
    checkOutput1({tag, "_bwr"}, bus_write, 1'b0);
    checkOutput32({tag, "_baddr"}, bus_address, 32'h0);
    checkOutput32({tag, "_bsel"}, {28'h0, bus_byte_select}, 32'h0);
    checkOutput32({tag, "_bwdata"}, bus_write_data, 32'h0);
    checkOutput32({tag, "_waddr"}, {27'h0, write_address}, 32'h0);
    checkOutput1({tag, "_wen"}, write_enable, 1'b0);
    checkOutput32({tag, "_wdata"}, write_data, 32'h0);
    checkOutput1({tag, "_valid"}, output_valid, 1'b0);
    checkOutput1({tag, "_mis"}, exception_misaligned, 1'b0);
    checkOutput1({tag, "_berr"}, exception_bus_error, 1'b0);
  endtask

  // One operation from presentation to completion. ack_at is the BUS cycle
  // (0 = first) in which acknowledge is given; values >= TO never ack.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at,
                       input logic [4:0] dest, input logic wen);
    int  sz;
    bit  aligned;
    bit  acked;
    int  exp_cycles;
    int  stall_cycles;
    bit  done;
    logic [31:0] junk;
    sz           = op_size(op);
    aligned      = (sz == 0) || ((addr % 32'(sz)) == 32'd0);
    acked        = (ack_at >= 0) && (ack_at < TO);
    exp_cycles   = acked ? ack_at + 1 : TO;
    stall_cycles = 0;
    bus_acknowledge = 1'b0;
    applyStimulus(1'b1, op, addr, dest, wen, sdata);
    #1;
    if (stall_request) stall_cycles++;
    nextCycle();
    if (sz == 0 || !aligned) begin
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 5'd0, 1'b0, 32'h0);
      checkOutput32({tag, "_stall"}, 32'(stall_cycles), 32'd0);
      checkOutput1({tag, "_valid"}, output_valid, 1'b1);
      checkOutput1({tag, "_req"}, bus_request, 1'b0);
      checkOutput1({tag, "_mis"}, exception_misaligned, (sz != 0));
      checkOutput1({tag, "_berr"}, exception_bus_error, 1'b0);
      checkOutput1({tag, "_wen"}, write_enable, (sz == 0) ? wen : 1'b0);
      if (sz == 0) begin
        checkOutput32({tag, "_wdata"}, write_data, addr);
        checkOutput32({tag, "_waddr"}, {27'h0, write_address}, {27'h0, dest});
      end
    end else begin
      done = 1'b0;
      for (int k = 0; k < TO + 2 && !done; k++) begin
        checkOutput1({tag, "_req_hold"}, bus_request, 1'b1);
        checkOutput1({tag, "_valid_busy"}, output_valid, 1'b0);
        checkOutput32({tag, "_baddr"}, bus_address, addr & 32'hFFFF_FFFC);
        checkOutput32({tag, "_bsel"}, {28'h0, bus_byte_select}, {28'h0, exp_be(op, addr)});
        checkOutput1({tag, "_bwr"}, bus_write, !op_loads(op));
        if (!op_loads(op))
          checkOutput32({tag, "_bwdata"}, bus_write_data, exp_store(op, sdata));
        if (k == ack_at) begin
          bus_acknowledge = 1'b1;
          bus_read_data   = rdata;
          done            = 1'b1;
        end else begin
          junk            = $urandom;
          bus_acknowledge = 1'b0;
          bus_read_data   = junk;
          if (k == TO - 1) done = 1'b1;
        end
        #1;
        if (stall_request) stall_cycles++;
        nextCycle();
      end
      bus_acknowledge = 1'b0;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 5'd0, 1'b0, 32'h0);
      checkOutput32({tag, "_stall"}, 32'(stall_cycles), 32'(exp_cycles));
      checkOutput1({tag, "_req_done"}, bus_request, 1'b0);
      checkOutput1({tag, "_valid"}, output_valid, 1'b1);
      checkOutput1({tag, "_mis"}, exception_misaligned, 1'b0);
      checkOutput1({tag, "_berr"}, exception_bus_error, !acked);
      checkOutput1({tag, "_wen"}, write_enable, acked && op_loads(op) && wen);
      if (acked && op_loads(op)) begin
        checkOutput32({tag, "_wdata"}, write_data, exp_load(op, addr, rdata));
        checkOutput32({tag, "_waddr"}, {27'h0, write_address}, {27'h0, dest});
      end
    end
    nextCycle();
    checkOutput1({tag, "_valid_after"}, output_valid, 1'b0);
    checkOutput1({tag, "_mis_after"}, exception_misaligned, 1'b0);
    checkOutput1({tag, "_berr_after"}, exception_bus_error, 1'b0);
    checkOutput1({tag, "_wen_after"}, write_enable, 1'b0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] raddr, rsd, rrd;
    logic [4:0]  rdest;
    logic        rwen;
    int          rack;

    reset = 1'b1;
    bus_acknowledge = 1'b0;
    bus_read_data   = 32'h0;
    applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) nextCycle();
    checkResetState("reset");
    checkOutput1("reset_stall", stall_request, 1'b0);
    reset = 1'b0;
    nextCycle();
    checkOutput1("idle_valid", output_valid, 1'b0);

    runOp("none", MEM_OP_NONE, 32'h0000_1234, 32'h0, 32'h0, -1, 5'd5, 1'b1);
    runOp("lb", MEM_OP_LB, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 5'd7, 1'b1);
    runOp("lbu", MEM_OP_LBU, 32'h0000_0103, 32'h0, 32'h80FF_0000, 3, 5'd7, 1'b1);
    runOp("lh_early", MEM_OP_LH, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 1, 5'd3, 1'b1);
    runOp("sh", MEM_OP_SH, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 5'd2, 1'b1);
    runOp("lw_mis", MEM_OP_LW, 32'h0000_0006, 32'h0, 32'h0, 0, 5'd4, 1'b1);
    runOp("lw_timeout", MEM_OP_LW, 32'h0000_0040, 32'h0, 32'h0, -1, 5'd6, 1'b1);
    runOp("lw_ack_at_to", MEM_OP_LW, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, TO - 1, 5'd8, 1'b1);
    runOp("undef_op", 4'hC, 32'h0000_00F1, 32'h0, 32'h0, -1, 5'd0, 1'b1);

    bus_acknowledge = 1'b1;
    nextCycle();
    bus_acknowledge = 1'b0;
    checkOutput1("idle_ack_valid", output_valid, 1'b0);
    checkOutput1("idle_ack_req", bus_request, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop   = 4'($urandom_range(0, 15));
      raddr = $urandom;
      rsd   = $urandom;
      rrd   = $urandom;
      rdest = 5'($urandom_range(0, 31));
      rwen  = 1'($urandom_range(0, 1));
      rack  = int'($urandom_range(0, TO + 1));
      if ($urandom_range(0, 1) == 0) raddr = raddr & 32'hFFFF_FFFC;
      runOp("rand", rop, raddr, rsd, rrd, rack, rdest, rwen);
    end

    applyStimulus(1'b1, MEM_OP_LW, 32'h0000_0400, 5'd9, 1'b1, 32'h0);
    #1;
    checkOutput1("rst_stall_idle", stall_request, 1'b1);
    nextCycle();
    checkOutput1("rst_req_before", bus_request, 1'b1);
    applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 5'd0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checkResetState("rst_mid");
    checkOutput1("rst_mid_stall", stall_request, 1'b0);
    nextCycle();
    reset = 1'b0;
    bus_acknowledge = 1'b1;
    nextCycle();
    bus_acknowledge = 1'b0;
    checkOutput1("rst_no_valid", output_valid, 1'b0);
    runOp("after_rst", MEM_OP_NONE, 32'h0000_CAFE, 32'h0, 32'h0, -1, 5'd11, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage that sits directly downstream of the execute stage. Receives the execute stage's destination address, write enable, result, and a memory operator.
- Runs load/store transactions on a request/acknowledge data bus, with byte/halfword lane steering and sign/zero extension.
- Presents registered writeback outputs to the writeback stage.
- Stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: BUS-state cycles without acknowledge before the transaction is aborted; 0 disables the timeout.
- COUNTER_WIDTH, 16: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high (ENABLE level); clears all state
- input_valid  in  1  execute result present this cycle
- mem_operator  in  4  NONE/LB/LBU/LH/LHU/LW/SB/SH/SW
- input_write_address  in  5  destination register from execute
- input_write_enable  in  1  register write request from execute
- input_write_data  in  32  execute result; the effective address for memory ops
- store_data  in  32  rt value for stores
- stall_request  out  1  hold upstream registers (combinational)
- bus_request  out  1  registered transaction request
- bus_write  out  1  1 = store
- bus_address  out  32  word-aligned address, bits[1:0] = 0
- bus_byte_select  out  4  active byte lanes; lane0 = bits[7:0] (little-endian)
- bus_write_data  out  32  lane-steered store data
- bus_read_data  in  32  load data, valid with acknowledge
- bus_acknowledge  in  1  completes the transaction in the same cycle
- write_address  out  5  to writeback
- write_enable  out  1  to writeback
- write_data  out  32  to writeback
- output_valid  out  1  writeback outputs valid this cycle
- exception_misaligned  out  1  one-cycle pulse, aligned with output_valid
- exception_bus_error  out  1  one-cycle pulse on timeout, aligned with output_valid

Behaviour:
- Reset values:
  - All registered outputs = 0; state = IDLE; counter = 0.
  - Reset mid-transaction drops bus_request immediately (asynchronous) and discards the access; no output_valid is produced for it.
- States: IDLE, BUS.
- IDLE, input_valid=0:
  - output_valid=0 on the next edge; write_enable=0 on the next edge.
- IDLE, input_valid=1, mem_operator=NONE:
  - Pass-through, 1-cycle latency.
  - Next edge: write_address/write_enable/write_data = inputs; output_valid=1.
  - No stall.
- Alignment rule: LH/LHU/SH need address[0]=0; LW/SW need address[1:0]=0.
- Misaligned memory op:
  - No bus activity, no stall.
  - Next edge: output_valid=1, write_enable=0, exception_misaligned=1.
- Aligned memory op in IDLE:
  - stall_request=1 combinationally.
  - Next edge: state=BUS, bus_request=1, counter=0.
  - Latch address, bus_write, byte_select, bus_write_data, destination address, enable, operator.
  - Bus outputs stay stable for the whole of BUS.
- BUS state:
  - stall_request = !bus_acknowledge && !timeout, where timeout = (TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1).
  - Counter increments each cycle without acknowledge.
- Acknowledge in BUS; on the next edge:
  - bus_request=0, state=IDLE, output_valid=1.
  - Loads: write_enable=latched enable, write_data=extended load value.
  - Stores: write_enable=0.
  - Upstream advances on this same edge because stall is already low.
- Timeout in BUS: next edge bus_request=0, state=IDLE, output_valid=1, write_enable=0, exception_bus_error=1.
- Acknowledge in IDLE is ignored. Acknowledge and timeout in the same cycle: acknowledge wins.
- Byte select:
  - LB/LBU/SB: one-hot of address[1:0].
  - LH/LHU/SH: 0011 when address[1]=0, 1100 when address[1]=1.
  - LW/SW: 1111.
- Store data:
  - SB replicates store_data[7:0] to all lanes.
  - SH replicates store_data[15:0] to both halves.
  - SW passes store_data through.
- Load extension:
  - LB/LH sign-extend the selected lane to 32 bits; LBU/LHU zero-extend.
  - LW passes bus_read_data through.
- Undefined mem_operator codes are treated as NONE.
- Write to register 0 is passed through; writeback suppresses it.

Decomposition:
- Shared include file (alongside existing ALU macros) holds:
  - MEM_OP_* 4-bit codes (NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW = 1..8).
  - MEM_OPERATOR_BUS width macro.
  - State codes.
- One combinational sub-module, mem_lane_steer: operator + address[1:0] + store_data + read_data → byte_select, steered write data, extended load data.
- FSM, timeout counter and output registers stay in mem_access.

Test Plan:
- NONE op, input_write_data=0x0000_1234, address 5, enable 1 → next cycle output_valid=1, write_data=0x0000_1234, write_address=5, stall never asserted.
- LB at 0x0000_0103; bus_read_data=0x80FF_0000 acked after 3 cycles → bus_address=0x100, byte_select=1000, stall held 4 cycles, write_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x0000_0202, store_data=0x1234_ABCD, ack next cycle → bus_write=1, byte_select=1100, bus_write_data=0xABCD_ABCD, write_enable=0.
- LW at 0x0000_0006 → no bus_request, output_valid=1, write_enable=0, exception_misaligned=1 for exactly one cycle.
- TIMEOUT_CYCLES=4, LW with no ack → bus_request high 4 cycles then low, exception_bus_error=1, stall drops. Ack and timeout in the same cycle → load data written, no error.
- Assert reset during BUS → bus_request=0 immediately, all outputs 0. After release, a pass-through op completes normally.
